// File: rtl/batalha_pkg.sv
// Shared Batalha Naval definitions: ship types, fleet-vector field offsets,
// per-type ship size and the shot-resolver FSM encoding.
package batalha_pkg;

  localparam logic [2:0] PORTA_AVIOES = 3'd0;
  localparam logic [2:0] ENCOURACADO  = 3'd1;
  localparam logic [2:0] HIDROAVIAO   = 3'd2;
  localparam logic [2:0] CRUZADOR     = 3'd3;
  localparam logic [2:0] SUBMARINO    = 3'd4;

  localparam int NUM_SLOTS = 5;
  localparam int TIPO_MSB  = 2;
  localparam int POS_LSB   = 3;   // slot i: x at POS_LSB+8i, y right above it
  localparam int SLOT_BITS = 8;
  localparam int CNT_LSB   = 43;
  localparam int CNT_MSB   = 46;
  localparam int MASK_LSB  = 47;
  localparam int MASK_MSB  = 51;

  typedef logic [2:0] estado_t;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LER       = 3'd1;
  localparam logic [2:0] VERIFICAR = 3'd2;
  localparam logic [2:0] ESCREVER  = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  function automatic logic [2:0] tam_por_tipo(input logic [2:0] tipo);
    case (tipo)
      PORTA_AVIOES: return 3'd5;
      ENCOURACADO:  return 3'd4;
      HIDROAVIAO:   return 3'd3;
      CRUZADOR:     return 3'd2;
      SUBMARINO:    return 3'd1;
      default:      return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/verificador_tiro_if.sv
// Request/memory/result bundle of the shot resolver. fim_jogo exists only
// when VERIFICADOR_TIRO_FROTA_EN is defined.
interface verificador_tiro_if;

  logic        start;
  logic [3:0]  x;
  logic [3:0]  y;
  logic        jogador;
  logic [63:0] vetor_leitura;
  logic [4:0]  read_addr;
  logic [4:0]  write_addr;
  logic [63:0] vetor_escrita;
  logic        wrep1;
  logic        wrep2;
  logic        ocupado;
  logic        ready;
  logic        acerto;
  logic        afundou;
  logic        repetido;
  logic        invalido;
`ifdef VERIFICADOR_TIRO_FROTA_EN
  logic        fim_jogo;
`endif

  modport master (
    output start, x, y, jogador, vetor_leitura,
    input  read_addr, write_addr, vetor_escrita, wrep1, wrep2,
    input  ocupado, ready, acerto, afundou, repetido, invalido
`ifdef VERIFICADOR_TIRO_FROTA_EN
    , input fim_jogo
`endif
  );

  modport slave (
    input  start, x, y, jogador, vetor_leitura,
    output read_addr, write_addr, vetor_escrita, wrep1, wrep2,
    output ocupado, ready, acerto, afundou, repetido, invalido
`ifdef VERIFICADOR_TIRO_FROTA_EN
    , output fim_jogo
`endif
  );

endinterface

// File: rtl/comparador_slots.sv
// Combinational match of a shot coordinate against the valid slots of one
// fleet vector; reports the first matching slot and whether it was already hit.
module comparador_slots
  import batalha_pkg::*;
(
  input  logic [63:0] vetor,
  input  logic [3:0]  x,
  input  logic [3:0]  y,
  output logic        match,
  output logic [2:0]  slot,
  output logic        ja_acertado
);

  logic [NUM_SLOTS-1:0] igual;
  logic [2:0]           tam;
  logic                 vazio;
  logic                 unused_bits;

  assign tam         = tam_por_tipo(vetor[TIPO_MSB:0]);
  assign vazio       = (vetor[CNT_MSB:CNT_LSB] == 4'd0) && (vetor[MASK_MSB:MASK_LSB] == 5'd0);
  assign unused_bits = ^vetor[63:52];

  // Slots beyond the ship size may hold stale coordinates and must never match.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    assign igual[gi] = !vazio && (3'(gi) < tam)
                    && (vetor[POS_LSB + SLOT_BITS*gi +: 4] == x)
                    && (vetor[POS_LSB + SLOT_BITS*gi + 4 +: 4] == y);
  end

  always_comb begin
    match = 1'b0;
    slot  = 3'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (igual[i]) begin
        match = 1'b1;
        slot  = 3'(i);
      end
    end
  end

  assign ja_acertado = match && vetor[MASK_LSB + int'(slot)];

endmodule

// File: rtl/verificador_tiro.sv
// Shot resolver: scans a player's fleet memory, writes back the hit vector and
// reports the result. VERIFICADOR_TIRO_FROTA_EN adds sunk counters and fim_jogo.
module verificador_tiro
  import batalha_pkg::*;
#(
  parameter int NUM_ENTRADAS  = 11,
  parameter int TAM_TABULEIRO = 10
) (
  input logic               clk,
  input logic               rst_n,
  verificador_tiro_if.slave bus
);

  localparam logic [4:0] IDX_ULTIMO = 5'(NUM_ENTRADAS - 1);
  localparam logic [4:0] LIMITE     = 5'(TAM_TABULEIRO);

  estado_t     estado_reg;
  logic [4:0]  idx_reg;
  logic [4:0]  write_addr_reg;
  logic [3:0]  x_reg;
  logic [3:0]  y_reg;
  logic        jogador_reg;
  logic [63:0] vetor_escrita_reg;
  logic        acerto_reg;
  logic        afundou_reg;
  logic        repetido_reg;
  logic        invalido_reg;

  logic        match;
  logic [2:0]  slot;
  logic        ja_acertado;
  logic [3:0]  cnt_atual;
  logic [63:0] vetor_next;
  logic        coord_invalida;
  logic        pronto;
  logic        afunda_agora;

  comparador_slots u_comparador (
    .vetor       (bus.vetor_leitura),
    .x           (x_reg),
    .y           (y_reg),
    .match       (match),
    .slot        (slot),
    .ja_acertado (ja_acertado)
  );

  assign cnt_atual      = bus.vetor_leitura[CNT_MSB:CNT_LSB];
  assign coord_invalida = ({1'b0, bus.x} >= LIMITE) || ({1'b0, bus.y} >= LIMITE);
  assign afunda_agora   = (estado_reg == ESCREVER) && (vetor_escrita_reg[CNT_MSB:CNT_LSB] == 4'd0);

  // Saturating decrement keeps a corrupt zero count from wrapping to 15.
  always_comb begin
    vetor_next = bus.vetor_leitura;
    vetor_next[MASK_LSB + int'(slot)] = 1'b1;
    vetor_next[CNT_MSB:CNT_LSB] = (cnt_atual == 4'd0) ? 4'd0 : cnt_atual - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_reg        <= IDLE;
      idx_reg           <= '0;
      write_addr_reg    <= '0;
      x_reg             <= '0;
      y_reg             <= '0;
      jogador_reg       <= 1'b0;
      vetor_escrita_reg <= '0;
      acerto_reg        <= 1'b0;
      afundou_reg       <= 1'b0;
      repetido_reg      <= 1'b0;
      invalido_reg      <= 1'b0;
    end else begin
      case (estado_reg)
        IDLE: begin
          if (bus.start) begin
            x_reg        <= bus.x;
            y_reg        <= bus.y;
            jogador_reg  <= bus.jogador;
            idx_reg      <= '0;
            acerto_reg   <= 1'b0;
            afundou_reg  <= 1'b0;
            repetido_reg <= 1'b0;
            invalido_reg <= coord_invalida;
            estado_reg   <= coord_invalida ? DONE : LER;
          end
        end
        LER: estado_reg <= VERIFICAR;
        VERIFICAR: begin
          if (match) begin
            if (ja_acertado) begin
              repetido_reg <= 1'b1;
              estado_reg   <= DONE;
            end else begin
              vetor_escrita_reg <= vetor_next;
              write_addr_reg    <= idx_reg;
              estado_reg        <= ESCREVER;
            end
          end else if (idx_reg == IDX_ULTIMO) begin
            estado_reg <= DONE;
          end else begin
            idx_reg    <= idx_reg + 5'd1;
            estado_reg <= LER;
          end
        end
        ESCREVER: begin
          acerto_reg  <= 1'b1;
          afundou_reg <= afunda_agora;
          estado_reg  <= DONE;
        end
        DONE:    estado_reg <= IDLE;
        default: estado_reg <= IDLE;
      endcase
    end
  end

  assign pronto            = (estado_reg == DONE);
  assign bus.ready         = pronto;
  assign bus.ocupado       = (estado_reg != IDLE);
  assign bus.read_addr     = idx_reg;
  assign bus.write_addr    = write_addr_reg;
  assign bus.vetor_escrita = vetor_escrita_reg;
  assign bus.wrep1         = (estado_reg == ESCREVER) && !jogador_reg;
  assign bus.wrep2         = (estado_reg == ESCREVER) && jogador_reg;
  // Flags are held internally but only shown during the ready pulse.
  assign bus.acerto        = pronto && acerto_reg;
  assign bus.afundou       = pronto && afundou_reg;
  assign bus.repetido      = pronto && repetido_reg;
  assign bus.invalido      = pronto && invalido_reg;

`ifdef VERIFICADOR_TIRO_FROTA_EN
  localparam logic [3:0] FROTA_TOTAL = 4'(NUM_ENTRADAS);

  logic [1:0] fim_jogador;

  for (genvar gi = 0; gi < 2; gi++) begin : g_frota
    logic [3:0] afundados_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        afundados_reg <= '0;
      else if (afunda_agora && (jogador_reg == 1'(gi)) && (afundados_reg != FROTA_TOTAL))
        afundados_reg <= afundados_reg + 4'd1;
    end

    assign fim_jogador[gi] = (afundados_reg == FROTA_TOTAL);
  end

  assign bus.fim_jogo = |fim_jogador;
`endif

endmodule

// File: tb/tb_verificador_tiro.sv
// Randomized self-checking bench for verificador_tiro against a behavioural
// fleet model; covers fim_jogo when VERIFICADOR_TIRO_FROTA_EN is defined.
module tb_verificador_tiro;
  import batalha_pkg::*;

  localparam int NE = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  verificador_tiro_if bus();

  verificador_tiro #(.NUM_ENTRADAS(NE), .TAM_TABULEIRO(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [63:0] mem     [2][NE];
  logic [63:0] ref_mem [2][NE];
  logic        jog_tb;
  int          n_checks = 0;
  int          n_errors = 0;
  int          sunk_ref [2];

  always @(posedge clk)
    bus.vetor_leitura <= (bus.read_addr < 5'(NE)) ? mem[jog_tb][bus.read_addr] : 64'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, esp);
    end
  endtask

  function automatic int tam_ref(input logic [2:0] tipo);
    return (tipo <= 3'd4) ? 5 - int'(tipo) : 0;
  endfunction

  function automatic logic [63:0] monta(input logic [2:0] tipo, input int x0, input int y0,
                                        input bit horiz, input logic [3:0] cnt,
                                        input logic [4:0] mask, input logic [39:0] lixo,
                                        input logic [11:0] alto);
    logic [63:0] v;
    v = '0;
    v[42:3] = lixo;
    v[2:0] = tipo;
    for (int i = 0; i < tam_ref(tipo); i++) begin
      v[6+8*i -: 4]  = 4'(horiz ? x0 + i : x0);
      v[10+8*i -: 4] = 4'(horiz ? y0 : y0 + i);
    end
    v[46:43] = cnt;
    v[51:47] = mask;
    v[63:52] = alto;
    return v;
  endfunction

  task automatic put(input int j, input int k, input logic [63:0] v);
    mem[j][k] = v;
    ref_mem[j][k] = v;
  endtask

  task automatic limpa(input int j);
    for (int k = 0; k < NE; k++) put(j, k, 64'd0);
  endtask

  // Reference: first entry whose valid slots contain (x,y) decides the shot.
  task automatic modelo(input int x, input int y, input int j, output int lat,
                        output logic [3:0] fl, output int wa, output logic [63:0] wv);
    lat = 23; fl = 4'b0000; wa = -1; wv = '0;
    if (x >= 10 || y >= 10) begin
      lat = 1; fl = 4'b0001;
      return;
    end
    for (int k = 0; k < NE; k++) begin
      logic [63:0] v;
      int t, cnt;
      v = ref_mem[j][k];
      t = tam_ref(v[2:0]);
      cnt = int'(v[46:43]);
      if (v[46:43] == 4'd0 && v[51:47] == 5'd0) continue;
      for (int i = 0; i < t; i++) begin
        if (int'(v[6+8*i -: 4]) == x && int'(v[10+8*i -: 4]) == y) begin
          if (v[47+i]) begin
            lat = 3 + 2*k; fl = 4'b0010;
            return;
          end
          cnt = (cnt > 0) ? cnt - 1 : 0;
          wv = v;
          wv[47+i] = 1'b1;
          wv[46:43] = 4'(cnt);
          lat = 4 + 2*k; wa = k;
          fl = {1'b1, cnt == 0, 2'b00};
          ref_mem[j][k] = wv;
          if (cnt == 0) sunk_ref[j]++;
          return;
        end
      end
    end
  endtask

  task automatic disparo(input int x, input int y, input int j, input bit ruido,
                         output int lat, output logic [3:0] fl, output int nwr);
    int e_lat, e_wa, wa, wcyc;
    logic [3:0] e_fl, fora;
    logic [63:0] e_wv, wv;
    logic [1:0] wq;
    modelo(x, y, j, e_lat, e_fl, e_wa, e_wv);
    wa = -1; wv = '0; wcyc = -1; wq = 2'b00; fora = 4'b0000;
    lat = -1; fl = 4'b0000; nwr = 0;
    @(negedge clk);
    jog_tb = j[0];
    bus.x = 4'(x); bus.y = 4'(y); bus.jogador = j[0]; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("ocupado_c1", bus.ocupado, 1);
        check("read_addr_c1", bus.read_addr, 0);
      end
      if (ruido && c == 2) begin
        bus.x = 4'($urandom); bus.y = 4'($urandom); bus.jogador = 1'($urandom); bus.start = 1'b1;
      end
      if (c == 3) bus.start = 1'b0;
      if (bus.wrep1 || bus.wrep2) begin
        nwr++;
        wa = int'(bus.write_addr); wv = bus.vetor_escrita; wcyc = c;
        wq = {bus.wrep2, bus.wrep1};
        mem[bus.wrep2][bus.write_addr] = bus.vetor_escrita;
      end
      if (bus.ready) begin
        lat = c;
        fl = {bus.acerto, bus.afundou, bus.repetido, bus.invalido};
        break;
      end
      fora = fora | {bus.acerto, bus.afundou, bus.repetido, bus.invalido};
    end
    bus.start = 1'b0;
    check("latencia", lat, e_lat);
    check("flags", fl, e_fl);
    check("flags_fora_ready", fora, 0);
    check("n_escritas", nwr, (e_wa >= 0) ? 1 : 0);
    if (e_wa >= 0) begin
      check("write_addr", wa, e_wa);
      check("vetor_escrita", wv, e_wv);
      check("wrep_sel", wq, j[0] ? 2'b10 : 2'b01);
      check("ciclo_escrita", wcyc, e_lat - 1);
    end
    @(negedge clk);
    check("ready_pulso", bus.ready, 0);
    check("ocupado_fim", bus.ocupado, 0);
`ifdef VERIFICADOR_TIRO_FROTA_EN
    check("fim_jogo", bus.fim_jogo, (sunk_ref[0] >= NE || sunk_ref[1] >= NE) ? 1 : 0);
`endif
    $display("disparo p%0d (%0d,%0d): lat=%0d flags(ac,af,rep,inv)=%b escritas=%0d",
             j + 1, x, y, lat, fl, nwr);
  endtask

  task automatic frota_aleatoria(input int j);
    bit occ [10][10];
    for (int a = 0; a < 10; a++) for (int b = 0; b < 10; b++) occ[a][b] = 1'b0;
    for (int k = 0; k < NE; k++) begin
      logic [2:0] tipo;
      int t, x0, y0, r;
      bit horiz, livre, ok;
      r = $urandom % 10;
      put(j, k, 64'd0);
      if (r == 0) begin
        // empty entry with stale slot contents
        put(j, k, monta(3'($urandom), 0, 0, 1'b0, 4'd0, 5'd0, 40'({$urandom, $urandom}), 12'($urandom)));
        continue;
      end
      if (r == 1) begin
        put(j, k, monta(3'($urandom_range(5, 7)), 0, 0, 1'b0, 4'd3, 5'd0, 40'({$urandom, $urandom}), 12'($urandom)));
        continue;
      end
      tipo = 3'($urandom_range(0, 4));
      t = tam_ref(tipo);
      ok = 1'b0;
      for (int tent = 0; tent < 50 && !ok; tent++) begin
        horiz = 1'($urandom);
        x0 = $urandom_range(0, horiz ? 10 - t : 9);
        y0 = $urandom_range(0, horiz ? 9 : 10 - t);
        livre = 1'b1;
        for (int i = 0; i < t; i++)
          if (occ[horiz ? x0 + i : x0][horiz ? y0 : y0 + i]) livre = 1'b0;
        if (livre) begin
          ok = 1'b1;
          for (int i = 0; i < t; i++) occ[horiz ? x0 + i : x0][horiz ? y0 : y0 + i] = 1'b1;
          put(j, k, monta(tipo, x0, y0, horiz, 4'(t), 5'd0, 40'({$urandom, $urandom}), 12'($urandom)));
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nwr;
    logic [3:0] fl;
    bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.jogador = 1'b0; jog_tb = 1'b0;
    sunk_ref[0] = 0; sunk_ref[1] = 0;
    limpa(0); limpa(1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_saidas", {bus.read_addr, bus.write_addr, bus.wrep1, bus.wrep2, bus.ready,
                           bus.acerto, bus.afundou, bus.repetido, bus.invalido, bus.ocupado}, 0);
    check("reset_vetor", bus.vetor_escrita, 0);
    rst_n = 1'b1;

    put(0, 3, monta(PORTA_AVIOES, 2, 4, 1'b1, 4'd5, 5'd0, 40'd0, 12'd0));
    disparo(4, 4, 0, 1'b0, lat, fl, nwr);
    check("t1_lat", lat, 10);
    check("t1_flags", fl, 4'b1000);
    check("t1_mem", mem[0][3], monta(PORTA_AVIOES, 2, 4, 1'b1, 4'd4, 5'b00100, 40'd0, 12'd0));

    disparo(4, 4, 0, 1'b0, lat, fl, nwr);
    check("t2_lat", lat, 9);
    check("t2_flags", fl, 4'b0010);
    check("t2_nwr", nwr, 0);

    put(1, 0, monta(SUBMARINO, 7, 7, 1'b1, 4'd1, 5'd0, 40'd0, 12'd0));
    disparo(7, 7, 1, 1'b0, lat, fl, nwr);
    check("t3_lat", lat, 4);
    check("t3_flags", fl, 4'b1100);
    check("t3_cnt", mem[1][0][46:43], 0);

    limpa(0); limpa(1);
    disparo(0, 0, 0, 1'b0, lat, fl, nwr);
    check("t4_lat", lat, 23);
    check("t4_flags", fl, 4'b0000);
    check("t4_nwr", nwr, 0);

    disparo(10, 3, 0, 1'b0, lat, fl, nwr);
    check("t5_lat", lat, 1);
    check("t5_flags", fl, 4'b0001);

    // corrupt vector: zero count with another slot already hit
    put(0, 2, monta(CRUZADOR, 1, 1, 1'b0, 4'd0, 5'b00010, 40'd0, 12'd0));
    disparo(1, 1, 0, 1'b0, lat, fl, nwr);
    check("t6_flags", fl, 4'b1100);
    check("t6_cnt", mem[0][2][46:43], 0);

    for (int r = 0; r < 6; r++) begin
      frota_aleatoria(0);
      frota_aleatoria(1);
      for (int s = 0; s < 30; s++) begin
        int j, x, y, q, k, t, i;
        logic [63:0] v;
        j = $urandom % 2;
        q = $urandom % 10;
        x = $urandom_range(0, 9);
        y = $urandom_range(0, 9);
        if (q < 7) begin
          k = $urandom % NE;
          v = ref_mem[j][k];
          t = tam_ref(v[2:0]);
          if (t > 0) begin
            i = $urandom % t;
            x = int'(v[6+8*i -: 4]);
            y = int'(v[10+8*i -: 4]);
          end
        end else if (q == 9) begin
          x = $urandom_range(0, 15);
          y = $urandom_range(10, 15);
          if ($urandom % 2 == 1) begin
            k = x; x = y; y = k;
          end
        end
        disparo(x, y, j, (x < 10 && y < 10 && ($urandom % 3 == 0)), lat, fl, nwr);
      end
      for (int j = 0; j < 2; j++)
        for (int k = 0; k < NE; k++) check("mem_final", mem[j][k], ref_mem[j][k]);
    end

    begin
      int nw;
      nw = 0;
      limpa(0);
      put(0, 5, monta(SUBMARINO, 5, 5, 1'b1, 4'd1, 5'd0, 40'd0, 12'd0));
      @(negedge clk);
      jog_tb = 1'b0; bus.x = 4'd5; bus.y = 4'd5; bus.jogador = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (bus.wrep1 || bus.wrep2) nw++;
      end
      rst_n = 1'b0;
      #1;
      check("reset_meio_saidas", {bus.read_addr, bus.write_addr, bus.wrep1, bus.wrep2, bus.ready,
                                  bus.acerto, bus.afundou, bus.repetido, bus.invalido, bus.ocupado}, 0);
      check("reset_meio_vetor", bus.vetor_escrita, 0);
      repeat (2) begin
        @(negedge clk);
        if (bus.wrep1 || bus.wrep2) nw++;
      end
      rst_n = 1'b1;
      repeat (15) begin
        @(negedge clk);
        if (bus.wrep1 || bus.wrep2) nw++;
      end
      check("reset_sem_escrita", nw, 0);
      check("reset_mem", mem[0][5], ref_mem[0][5]);
      check("reset_ocioso", bus.ocupado, 0);
      sunk_ref[0] = 0; sunk_ref[1] = 0;
      $display("reset no ciclo 8: escritas=%0d", nw);
    end

`ifdef VERIFICADOR_TIRO_FROTA_EN
    for (int k = 0; k < NE; k++) put(0, k, monta(SUBMARINO, k % 10, k / 10, 1'b1, 4'd1, 5'd0, 40'd0, 12'd0));
    for (int k = 0; k < NE; k++) begin
      disparo(k % 10, k / 10, 0, 1'b0, lat, fl, nwr);
      if (k == NE - 2) check("fim_jogo_antes", bus.fim_jogo, 0);
    end
    check("fim_jogo_final", bus.fim_jogo, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/verificador_tiro.md
# verificador_tiro

Shot resolver for the Batalha Naval datapath. It takes a shot coordinate against one player's fleet memory and scans the 11 ship vectors stored there by the placement validator. On a hit it writes the updated vector back: hit mask set, remaining-piece count decremented. It then reports the result (miss, hit, sunk, repeated, invalid) to the game controller.

## Interface
Parameters:
- NUM_ENTRADAS, 11: ship vectors per player, at addresses 0..NUM_ENTRADAS-1.
- TAM_TABULEIRO, 10: board edge; valid coordinates are 0..TAM_TABULEIRO-1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- x  input  4  shot column.
- y  input  4  shot row.
- jogador  input  1  target fleet: 0 = p1 memory, 1 = p2 memory.
- vetor_leitura  input  64  memory read data; valid one cycle after read_addr.
- read_addr  output  5  memory read address.
- write_addr  output  5  memory write address.
- vetor_escrita  output  64  write-back vector.
- wrep1  output  1  write enable, p1 memory.
- wrep2  output  1  write enable, p2 memory.
- ocupado  output  1  high from the cycle after an accepted start until DONE.
- ready  output  1  one-cycle result-valid pulse.
- acerto  output  1  shot hit an unhit cell.
- afundou  output  1  that hit brought the piece count to 0.
- repetido  output  1  cell was already hit.
- invalido  output  1  coordinate is out of board.

## Operation
Vector layout (same as the placement side):
- [2:0] tipo.
- Slot i (i = 0..4): x at [6+8i -: 4], y at [10+8i -: 4].
- [46:43] remaining pieces.
- [51:47] hit mask; bit 47+i belongs to slot i.
- [63:52] pass through unchanged.

Slot validity:
- Slots valid per tipo: PORTA_AVIOES 5, ENCOURACADO 4, HIDROAVIAO 3, CRUZADOR 2, SUBMARINO 1.
- tipo > 4: entry has no valid slots.
- Count == 0 and mask == 0: empty entry, skipped. Zeroed memory therefore never matches (0,0).

FSM states: IDLE, LER, VERIFICAR, ESCREVER, DONE.
- IDLE: on start, latch x, y, jogador.
  - Either coordinate >= TAM_TABULEIRO: go to DONE with invalido.
  - Otherwise: idx = 0, go to LER.
- LER: drive read_addr = idx, go to VERIFICAR.
- VERIFICAR: compare the latched (x,y) against the valid slots of vetor_leitura.
  - Match with mask bit clear: build vetor_escrita = vetor_leitura with that mask bit set and count - 1. Go to ESCREVER.
  - Match with mask bit set: repetido, go to DONE.
  - No match and idx == NUM_ENTRADAS-1: miss, go to DONE.
  - No match otherwise: idx + 1, go to LER.
- ESCREVER: write_addr = idx; assert wrep1 if jogador == 0, else wrep2, for exactly one cycle. afundou = (new count == 0). Go to DONE.
- DONE: ready = 1 with the result flags, go to IDLE.

Rules:
- Ships never overlap, so the scan stops at the first match.
- Count decrement saturates at 0: a corrupt vector never wraps to 15.
- start outside IDLE is ignored.

## Timing
- Reset values: state IDLE; read_addr 0; write_addr 0; vetor_escrita 0; wrep1, wrep2, ready, acerto, afundou, repetido, invalido, ocupado all 0.
- Cycle 0 = start sampled. Entry k is read in cycle 1+2k and checked in cycle 2+2k.
- Latencies to ready:
  - Miss: cycle 23.
  - Hit at entry k: write in cycle 3+2k, ready in cycle 4+2k.
  - Repeated at entry k: ready in cycle 3+2k.
  - Invalid coordinate: ready in cycle 1.
- Result flags are valid only while ready = 1 and are 0 otherwise.
- A new start is accepted in the cycle after ready.
- rst_n asserted mid-scan or mid-write: immediate return to IDLE, all outputs 0, no write issued.

## Configuration
- Macro: VERIFICADOR_TIRO_FROTA_EN.
- Defined: per-player 4-bit sunk-ship counter.
  - Increments on each afundou.
  - Adds output fim_jogo (1 bit), high once the counter equals NUM_ENTRADAS; cleared only by rst_n.
- Undefined: no counter and no fim_jogo port.

## Structure
- Shared package batalha_pkg:
  - tipo constants (PORTA_AVIOES..SUBMARINO).
  - Field offsets: POS_LSB, CNT_MSB, MASK_LSB.
  - Size-per-tipo function.
  - FSM state typedef.
- One combinational sub-module, comparador_slots:
  - Inputs: vetor, x, y.
  - Outputs: match, slot index, already-hit.
- FSM and registers stay in verificador_tiro.

## Test plan
- p1 entry 3 = PORTA_AVIOES horizontal at (2,4), count 5; shoot (4,4) → write addr 3 with bit 49 set and count 4; acerto = 1, ready at cycle 10.
- Repeat the same shot → repetido = 1, no wrep, ready at cycle 9.
- p2 entry 0 = SUBMARINO at (7,7), count 1; shoot (7,7) with jogador = 1 → wrep2 pulse, count 0, afundou = 1, ready at cycle 4.
- Zeroed memory, shoot (0,0) → miss (all flags 0), ready at cycle 23, no write.
- Shoot (10,3) → invalido = 1 at cycle 1; read_addr stays 0.
- Assert rst_n low at cycle 8 of a scan → no wrep; with VERIFICADOR_TIRO_FROTA_EN, sink all 11 ships → fim_jogo = 1.
